// File: rtl/wb_initiator.sv
// rtl/wb_initiator.sv - single-outstanding Wishbone classic initiator with valid/ready command/response
// Optional bus-cycle abort on missing ack: define WB_INITIATOR_TIMEOUT_EN.
module wb_initiator #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_data_i,
  input  logic                  req_we_i,
  input  logic [3:0]            req_sel_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_data_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  output logic                  wb_we_o,
  output logic [3:0]            wb_sel_o,
  output logic                  wb_stb_o,
  output logic                  wb_cyc_o,
  input  logic                  wb_ack_i
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_initiator: TIMEOUT_CYCLES must be in 2..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_data_q, rsp_data_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [31:0]           dat_q, dat_d;
  logic                  we_q, we_d;
  logic [3:0]            sel_q, sel_d;
  // cyc and stb share one register: classic single transfers only
  logic                  cyc_q, cyc_d;

`ifdef WB_INITIATOR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      cyc_q       <= 1'b0;
`ifdef WB_INITIATOR_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      cyc_q       <= cyc_d;
`ifdef WB_INITIATOR_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    sel_d       = sel_q;
    cyc_d       = cyc_q;
`ifdef WB_INITIATOR_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          adr_d = req_addr_i;
          dat_d = req_data_i;
          we_d  = req_we_i;
          sel_d = req_sel_i;
          if (req_sel_i != 4'b0000) begin
            cyc_d   = 1'b1;
            state_d = S_BUS;
`ifdef WB_INITIATOR_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            // No lanes enabled: answer immediately without touching the bus
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            state_d     = S_RESP;
`ifdef WB_INITIATOR_TIMEOUT_EN
            err_d       = 1'b0;
`endif
          end
        end
      end
      S_BUS: begin
        if (wb_ack_i) begin
          rsp_data_d  = we_q ? 32'h0 : wb_dat_i;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          sel_d       = '0;
          dat_d       = '0;
          state_d     = S_RESP;
`ifdef WB_INITIATOR_TIMEOUT_EN
          err_d       = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d  = '0;
          rsp_valid_d = 1'b1;
          err_d       = 1'b1;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          sel_d       = '0;
          dat_d       = '0;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_we_o     = we_q;
  assign wb_sel_o    = sel_q;
  assign wb_stb_o    = cyc_q;
  assign wb_cyc_o    = cyc_q;
`ifdef WB_INITIATOR_TIMEOUT_EN
  assign rsp_err_o   = err_q;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_initiator.sv
// tb/tb_wb_initiator.sv - randomized scoreboard bench for wb_initiator against a GPIO-style responder model
module tb_wb_initiator;
  localparam int AW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_data;
  logic [3:0]    req_sel;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_data;
  logic [AW-1:0] wb_adr;
  logic [31:0]   wb_dat_o, wb_dat_i;
  logic          wb_we, wb_stb, wb_cyc, wb_ack;
  logic [3:0]    wb_sel;

  always #5 clk = ~clk;

  wb_initiator #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_we_i(req_we), .req_sel_i(req_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err), .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we), .wb_sel_o(wb_sel), .wb_stb_o(wb_stb), .wb_cyc_o(wb_cyc),
    .wb_ack_i(wb_ack)
  );

  // GPIO-like responder: upper half is a register, lower half reads input pins
  logic [31:0] gpio_q = '0;
  logic [15:0] pins = '0;
  logic        stall = 1'b0;
  logic        rand_ws = 1'b0;

  always @(posedge clk) begin
    if (rst) wb_ack <= 1'b0;
    else if (wb_cyc && wb_stb && !wb_ack && !stall && (!rand_ws || $urandom_range(0, 1) == 1)) begin
      wb_ack <= 1'b1;
      if (wb_we)
        for (int b = 0; b < 4; b++)
          if (wb_sel[b]) gpio_q[8*b +: 8] <= wb_dat_o[8*b +: 8];
    end else wb_ack <= 1'b0;
  end
  assign wb_dat_i = {gpio_q[31:16], pins};

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endfunction

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] m_reg = '0;

  function automatic exp_t model(logic we, logic [3:0] sel, logic [31:0] d);
    exp_t e;
    e.data = '0;
    e.err  = 1'b0;
    if (sel != 4'b0000) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) m_reg[8*b +: 8] = d[8*b +: 8];
      end else e.data = {m_reg[31:16], pins};
    end
    return e;
  endfunction

  // Scoreboard monitor: pops one expectation per response handshake
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got data 0x%08h err %0b want no response", rsp_data, rsp_err);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
      end
    end
  end

  // Strobe pulse length and cyc/stb coherence tracker
  int   stb_run = 0;
  int   last_stb = 0;
  logic cyc_seen = 1'b0;
  always @(negedge clk) begin
    if (!rst) chk("cyc_eq_stb", {31'b0, wb_cyc}, {31'b0, wb_stb});
    if (wb_cyc) cyc_seen = 1'b1;
    if (wb_stb) stb_run++;
    else if (stb_run != 0) begin
      last_stb = stb_run;
      stb_run  = 0;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic we, input logic [3:0] sel);
    bit ok = 0;
    @(posedge clk); #1;
    req_addr = a; req_data = d; req_we = we; req_sel = sel; req_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL req_accept: got no accept within 200 cycles want accept");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic we, input logic [3:0] sel);
    exp_q.push_back(model(we, sel, d));
    send(a, d, we, sel);
  endtask

  task automatic drain(input int bound);
    bit ok = 0;
    for (int n = 0; n < bound && !ok; n++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: got %0d pending responses want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    logic        quiet;
    bit          seen;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_we = 1'b0;
    req_sel = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_cyc", {31'b0, wb_cyc}, 32'h0);
    chk("rst_bus_regs", {wb_adr | wb_dat_o}, 32'h0);
    chk("rst_we_sel", {27'b0, wb_we, wb_sel}, 32'h0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    @(posedge clk); #1 rst = 1'b0;

    // Write 0xA5A5 with sel=0011, cycle-accurate latency
    issue(32'h0, 32'h0000_A5A5, 1'b1, 4'b0011);
    @(negedge clk);
    chk("wr_stb_c0", {30'b0, wb_stb, rsp_valid}, 32'h2);
    chk("wr_adr", wb_adr, 32'h0);
    @(negedge clk);
    chk("wr_stb_c1", {30'b0, wb_stb, rsp_valid}, 32'h2);
    @(negedge clk);
    chk("wr_stb_c2", {30'b0, wb_stb, rsp_valid}, 32'h1);
    drain(20);
    chk("wr_stb_len", last_stb, 2);
    chk("wr_gpio_reg", gpio_q, 32'h0000_A5A5);

    // Upper-half write then full-word read-back
    issue(32'h0, 32'h00FF_0000, 1'b1, 4'b1100);
    drain(20);
    pins = 16'($urandom);
    issue(32'h0, 32'h0, 1'b0, 4'b1111);
    drain(20);

    // Backpressure on a read with a competing request held
    rsp_ready = 1'b0;
    pins = 16'($urandom);
    issue(32'h4, 32'h0, 1'b0, 4'b1111);
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    chk("bp_valid_seen", {31'b0, seen}, 32'h1);
    held = rsp_data;
    exp_q.push_back(model(1'b1, 4'b0100, 32'h0033_0000));
    req_addr = 32'h8; req_data = 32'h0033_0000; req_we = 1'b1; req_sel = 4'b0100; req_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("bp_hold", {28'b0, rsp_valid, req_ready, wb_cyc, 1'b0}, 32'h8);
      chk("bp_data", rsp_data, held);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_valid", {31'b0, rsp_valid}, 32'h1);
    @(negedge clk);
    chk("bp_rel_done", {30'b0, rsp_valid, req_ready}, 32'h1);
    @(negedge clk);
    chk("bp_next_acc", {30'b0, wb_cyc, req_ready}, 32'h2);
    @(posedge clk); #1 req_valid = 1'b0;
    drain(20);

    // sel=0: no bus cycle, immediate zero response
    cyc_seen = 1'b0;
    issue(32'h0, 32'hDEAD_BEEF, 1'b0, 4'b0000);
    @(negedge clk);
    chk("sel0_rsp", {30'b0, rsp_valid, wb_cyc}, 32'h2);
    drain(20);
    chk("sel0_no_cyc", {31'b0, cyc_seen}, 32'h0);

    // Randomized traffic with wait states and response backpressure
    rand_ws = 1'b1;
    for (int t = 0; t < 40; t++) begin
      logic [3:0] s;
      s = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
      pins = 16'($urandom);
      rsp_ready = 1'b0;
      issue($urandom, $urandom, 1'($urandom), s);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 rsp_ready = 1'b1;
      drain(100);
    end
    rand_ws = 1'b0;

    // Reset in the middle of a stalled bus cycle
    stall = 1'b1;
    send(32'h0, 32'h0, 1'b0, 4'b1111);
    repeat (3) @(negedge clk);
    chk("mid_stb_before", {31'b0, wb_stb}, 32'h1);
    pulse_reset();
    @(negedge clk);
    chk("mid_stb_after", {30'b0, wb_cyc, wb_stb}, 32'h0);
    quiet = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (rsp_valid) quiet = 1'b0;
    end
    chk("mid_no_rsp", {31'b0, quiet}, 32'h1);
    stall = 1'b0;
    pins = 16'($urandom);
    issue(32'h0, 32'h0, 1'b0, 4'b1111);
    drain(20);

    // Never-acking responder
    stall = 1'b1;
`ifdef WB_INITIATOR_TIMEOUT_EN
    exp_q.push_back('{data: 32'h0, err: 1'b1});
    send(32'h10, 32'h0, 1'b0, 4'b1111);
    drain(50);
    chk("to_stb_len", last_stb, TO);
`else
    send(32'h10, 32'h0, 1'b0, 4'b1111);
    repeat (100) @(negedge clk);
    chk("noto_stb_held", {30'b0, wb_cyc, wb_stb}, 32'h3);
    pulse_reset();
`endif
    stall = 1'b0;
    issue(32'h0, 32'h1234_5678, 1'b1, 4'b1000);
    drain(20);
    chk("final_gpio_hi", {16'b0, gpio_q[31:16]}, {16'b0, m_reg[31:16]});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
- Single-outstanding Wishbone classic initiator (bus master).
- Converts a simple valid/ready command interface, driven by a core, debug bridge or test engine, into one Wishbone read or write cycle.
- Returns read data or completion status on a valid/ready response channel.
- Sits upstream of uncore Wishbone responders such as the GPIO block.

Parameters:
- ADDR_WIDTH, 32: width of wb_adr_o and req_addr_i.
- TIMEOUT_CYCLES, 256: maximum BUS-state cycles without ack before the cycle is aborted. Used only with the optional feature; legal range 2..65535.

Ports:
- wb_clk_i  in  1  system clock; all logic on its rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  command valid.
- req_ready_o  out  1  command accepted when high together with req_valid_i.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_data_i  in  32  write data.
- req_we_i  in  1  1 = write, 0 = read.
- req_sel_i  in  4  byte selects.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when high together with rsp_valid_o.
- rsp_data_o  out  32  read data; 0 for writes, errors and sel=0.
- rsp_err_o  out  1  cycle aborted by timeout.
- wb_adr_o  out  ADDR_WIDTH  Wishbone address.
- wb_dat_o  out  32  Wishbone write data.
- wb_dat_i  in  32  Wishbone read data.
- wb_we_o  out  1  Wishbone write enable.
- wb_sel_o  out  4  Wishbone byte selects.
- wb_stb_o  out  1  Wishbone strobe.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_ack_i  in  1  Wishbone acknowledge.

Behaviour:
- Clocking and reset: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- Register outputs: all outputs are registered except req_ready_o, which is decoded from state.
- Reset values: state IDLE; rsp_valid_o=0, rsp_err_o=0, rsp_data_o=0, wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_sel_o=0, wb_adr_o=0, wb_dat_o=0, timeout counter 0.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch addr/data/we/sel into the wb_* output registers.
  - sel!=0: assert wb_cyc_o=wb_stb_o=1 and go to BUS.
  - sel==0: no bus cycle; go to RESP with rsp_data_o=0, rsp_err_o=0.
- BUS:
  - req_ready_o=0; cyc, stb and all wb_* outputs held stable.
  - wb_ack_i sampled high at an edge:
    - capture wb_dat_i into rsp_data_o for reads, 0 for writes;
    - clear cyc, stb, we, sel, dat;
    - rsp_valid_o=1, rsp_err_o=0; go to RESP.
  - stb drops on the same edge ack is seen, so a responder of the form ack<=stb&!ack produces exactly one ack.
  - ack outside BUS is ignored.
- RESP:
  - rsp_valid_o held with data and err stable until rsp_ready_i.
  - On rsp_ready_i: clear rsp_valid_o; go to IDLE. The next request can be accepted the following cycle.
- Latency against a zero-wait registered-ack responder:
  - command accepted at edge N;
  - stb high from N to N+2;
  - ack sampled at N+2;
  - rsp_valid_o high after N+2.
- Throughput: one transaction per 4 cycles with rsp_ready_i tied high.
- Backpressure: rsp_ready_i low holds RESP indefinitely; req_ready_o stays 0.
- Reset mid-operation: wb_rst_i at any edge forces IDLE and drops cyc/stb in the same edge. The pending response is discarded, with no rsp_valid_o afterwards.
- Simultaneous reset and ack: reset wins.
- wb_cyc_o and wb_stb_o are always equal (no block transfers).

Optional Feature:
- Macro: WB_INITIATOR_TIMEOUT_EN.
- Defined:
  - a counter of width ceil(log2(TIMEOUT_CYCLES+1)) clears on entry to BUS and increments each BUS cycle without ack;
  - when it reaches TIMEOUT_CYCLES-1 with no ack, the next edge clears cyc/stb and goes to RESP with rsp_err_o=1, rsp_data_o=0;
  - ack on the same edge as expiry takes priority (normal completion, err=0).
- Not defined:
  - no counter; BUS waits forever for ack;
  - rsp_err_o is constant 0;
  - TIMEOUT_CYCLES is unused.

Test Plan:
- Write, GPIO-style responder: req addr=0x0, data=0x0000_A5A5, we=1, sel=4'b0011.
  - Required: one stb pulse, 2 cycles; responder state register=0xA5A5; rsp_valid_o 2 cycles after accept; rsp_data_o=0, rsp_err_o=0.
- Read-back: write data=0x00FF_0000 with sel=4'b1100, then read with sel=4'b1111.
  - Required: rsp_data_o[31:16]=0x00FF; rsp_data_o[15:0] equals the pin values driven by the bench.
- Backpressure: rsp_ready_i held low 10 cycles after a read.
  - Required: rsp_valid_o, rsp_data_o stable; req_ready_o=0; new req_valid_i not accepted.
  - Release: completes in 1 cycle; next request accepted on the following cycle.
- sel=0 request.
  - Required: wb_cyc_o never asserts; rsp_valid_o next cycle with data 0, err 0.
- Timeout, macro defined, TIMEOUT_CYCLES=8, responder never acks.
  - Required: stb high exactly 8 cycles, then rsp_err_o=1, rsp_data_o=0.
  - Without the macro: stb remains high after 100 cycles.
- Reset mid-cycle: wb_rst_i pulsed 1 cycle while in BUS with a stalled responder.
  - Required: cyc/stb low after that edge; no rsp_valid_o; next request completes normally.
